// File: rtl/laser_scheduler.sv
// rtl/laser_scheduler.sv - round-robin scheduler sharing one laser engine across four cannon lanes
module laser_scheduler #(
    parameter int LASER_START    = 256,
    parameter int STEP           = 2,
    parameter int HIT_DIST       = 76,
    parameter int COOLDOWN_TICKS = 8
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       move_tick,
    input  logic [3:0] fire_req,
    input  logic [3:0] monster_present,
    output logic       laser_active,
    output logic [1:0] laser_dir,
    output logic [8:0] laser_dist,
    output logic [3:0] kill,
    output logic       busy,
    output logic [7:0] score
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FIRE = 2'd1;
    localparam logic [1:0] S_COOL = 2'd2;

    localparam int         CW        = (COOLDOWN_TICKS > 1) ? $clog2(COOLDOWN_TICKS + 1) : 1;
    localparam logic [8:0] START_D   = 9'(LASER_START);
    localparam logic [9:0] STEP_D    = 10'(STEP);
    // dist - STEP <= HIT_DIST rewritten as dist <= HIT_DIST + STEP so nothing can underflow
    localparam logic [9:0] HIT_LIMIT = 10'(HIT_DIST + STEP);

    logic [1:0]    state;
    logic [1:0]    rr_ptr;
    logic [1:0]    grant;
    logic [CW-1:0] cool_cnt;
    logic [9:0]    dist_ext;
    logic          hit;
    logic          miss;

    // Scan from the farthest offset down so the nearest set bit at or above rr_ptr wins.
    always_comb begin
        grant = rr_ptr;
        for (int i = 3; i >= 0; i--) begin
            if (fire_req[rr_ptr + 2'(i)]) begin
                grant = rr_ptr + 2'(i);
            end
        end
    end

    always_comb begin
        dist_ext = {1'b0, laser_dist};
        hit      = monster_present[laser_dir] && (dist_ext <= HIT_LIMIT);
        miss     = dist_ext <= STEP_D;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= S_IDLE;
            laser_active <= 1'b0;
            laser_dir    <= 2'd0;
            laser_dist   <= START_D;
            kill         <= 4'b0000;
            busy         <= 1'b0;
            score        <= 8'd0;
            rr_ptr       <= 2'd0;
            cool_cnt     <= '0;
        end else begin
            kill <= 4'b0000;
            case (state)
                S_IDLE: begin
                    if (|fire_req) begin
                        state        <= S_FIRE;
                        laser_dir    <= grant;
                        laser_dist   <= START_D;
                        laser_active <= 1'b1;
                        busy         <= 1'b1;
                        rr_ptr       <= grant + 2'd1;
                    end
                end
                S_FIRE: begin
                    if (move_tick) begin
                        if (hit || miss) begin
                            if (hit) begin
                                kill  <= 4'b0001 << laser_dir;
                                score <= (score == 8'hFF) ? score : score + 8'd1;
                            end
                            laser_dist   <= START_D;
                            laser_active <= 1'b0;
                            if (COOLDOWN_TICKS == 0) begin
                                state <= S_IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state    <= S_COOL;
                                cool_cnt <= CW'(COOLDOWN_TICKS);
                            end
                        end else begin
                            laser_dist <= laser_dist - STEP_D[8:0];
                        end
                    end
                end
                S_COOL: begin
                    if (move_tick) begin
                        if (cool_cnt <= CW'(1)) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            cool_cnt <= cool_cnt - CW'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
